gobou_ctrl: RTL and testbench

GOBOU_CTRL -- requirements
Module: gobou_ctrl

---
 rtl/gobou_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_gobou_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gobou_ctrl.sv
// Sequencer for the gobou MAC array: walks weight, bias and output phases per CORE-wide block.
// Optional ReLU enable on write-back is built in when GOBOU_CTRL_RELU_EN is defined.
module gobou_ctrl #(
    parameter int CORE    = 8,
    parameter int LWIDTH  = 10,
    parameter int IMGSIZE = 12,
    parameter int NETSIZE = 14
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      req,
    input  logic [LWIDTH-1:0]         total_out,
    input  logic [LWIDTH-1:0]         total_in,
    input  logic [IMGSIZE-1:0]        in_offset,
    input  logic [IMGSIZE-1:0]        out_offset,
    input  logic [NETSIZE-1:0]        net_offset,
    output logic                      ack,
    output logic [IMGSIZE-1:0]        mem_img_addr,
    output logic                      img_we,
    output logic [NETSIZE-1:0]        mem_net_addr,
    output logic                      acc_clr,
    output logic                      mac_oe,
    output logic                      bias_oe,
    output logic [$clog2(CORE)-1:0]   out_sel,
    output logic                      relu_oe
);

    // state    | meaning
    // S_WAIT   | idle, ack high, sampling req
    // S_WEIGHT | one input element per cycle, weight and image reads
    // S_BIAS   | single bias read for the current block
    // S_OUTPUT | write back up to CORE results, one lane per cycle
    typedef enum logic [1:0] {S_WAIT, S_WEIGHT, S_BIAS, S_OUTPUT} state_t;

    localparam int SELW = $clog2(CORE);
    localparam int CW   = LWIDTH + 1;

    state_t              state_q, state_d;
    logic [LWIDTH-1:0]   in_cnt_q, in_cnt_d;
    logic [CW-1:0]       out_cnt_q, out_cnt_d;
    logic [SELW-1:0]     k_q, k_d;
    logic [NETSIZE-1:0]  net_ptr_q, net_ptr_d;
    logic [LWIDTH-1:0]   tin_q, tin_d;
    logic [LWIDTH-1:0]   tout_q, tout_d;
    logic [IMGSIZE-1:0]  in_off_q, in_off_d;
    logic [IMGSIZE-1:0]  out_off_q, out_off_d;

    logic                ack_q, ack_d;
    logic [IMGSIZE-1:0]  img_addr_q, img_addr_d;
    logic                img_we_q, img_we_d;
    logic [NETSIZE-1:0]  net_addr_q, net_addr_d;
    logic [SELW-1:0]     out_sel_q, out_sel_d;
    logic                acc_clr_q, acc_clr_d;
    logic                mac_oe_q, mac_oe_d;
    logic                bias_oe_q, bias_oe_d;
`ifdef GOBOU_CTRL_RELU_EN
    logic                relu_q, relu_d;
`endif

    logic [CW-1:0]       rem;
    logic [CW-1:0]       nxt_out;
    logic                last_out;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        k_d       = k_q;
        net_ptr_d = net_ptr_q;
        tin_d     = tin_q;
        tout_d    = tout_q;
        in_off_d  = in_off_q;
        out_off_d = out_off_q;

        rem      = {1'b0, tout_q} - out_cnt_q;
        nxt_out  = out_cnt_q + CW'(CORE);
        last_out = (k_q == SELW'(CORE - 1)) || ((CW'(k_q) + CW'(1)) == rem);

        case (state_q)
            S_WAIT: begin
                if (req && (total_in != '0) && (total_out != '0)) begin
                    tin_d     = total_in;
                    tout_d    = total_out;
                    in_off_d  = in_offset;
                    out_off_d = out_offset;
                    net_ptr_d = net_offset;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = S_WEIGHT;
                end
            end
            S_WEIGHT: begin
                in_cnt_d  = in_cnt_q + LWIDTH'(1);
                net_ptr_d = net_ptr_q + NETSIZE'(1);
                if (in_cnt_q == tin_q - LWIDTH'(1)) begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                net_ptr_d = net_ptr_q + NETSIZE'(1);
                k_d       = '0;
                state_d   = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (last_out) begin
                    out_cnt_d = nxt_out;
                    in_cnt_d  = '0;
                    state_d   = (nxt_out < {1'b0, tout_q}) ? S_WEIGHT : S_WAIT;
                end else begin
                    k_d = k_q + SELW'(1);
                end
            end
            default: state_d = S_WAIT;
        endcase

        // Address/strobe registers show the values belonging to the state being entered.
        ack_d      = (state_d == S_WAIT);
        img_we_d   = (state_d == S_OUTPUT);
        out_sel_d  = (state_d == S_OUTPUT) ? k_d : '0;
        img_addr_d = '0;
        if (state_d == S_WEIGHT) begin
            img_addr_d = in_off_d + IMGSIZE'(in_cnt_d);
        end else if (state_d == S_OUTPUT) begin
            img_addr_d = out_off_d + IMGSIZE'(out_cnt_d) + IMGSIZE'(k_d);
        end
        net_addr_d = ((state_d == S_WEIGHT) || (state_d == S_BIAS)) ? net_ptr_d : '0;

        // Core strobes trail the address phase by the one-cycle memory read latency.
        mac_oe_d  = (state_q == S_WEIGHT);
        acc_clr_d = (state_q == S_WEIGHT) && (in_cnt_q == '0);
        bias_oe_d = (state_q == S_BIAS);
`ifdef GOBOU_CTRL_RELU_EN
        relu_d    = (state_d == S_OUTPUT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_q    <= S_WAIT;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            k_q        <= '0;
            net_ptr_q  <= '0;
            tin_q      <= '0;
            tout_q     <= '0;
            in_off_q   <= '0;
            out_off_q  <= '0;
            ack_q      <= 1'b1;
            img_addr_q <= '0;
            img_we_q   <= 1'b0;
            net_addr_q <= '0;
            out_sel_q  <= '0;
            acc_clr_q  <= 1'b0;
            mac_oe_q   <= 1'b0;
            bias_oe_q  <= 1'b0;
`ifdef GOBOU_CTRL_RELU_EN
            relu_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            k_q        <= k_d;
            net_ptr_q  <= net_ptr_d;
            tin_q      <= tin_d;
            tout_q     <= tout_d;
            in_off_q   <= in_off_d;
            out_off_q  <= out_off_d;
            ack_q      <= ack_d;
            img_addr_q <= img_addr_d;
            img_we_q   <= img_we_d;
            net_addr_q <= net_addr_d;
            out_sel_q  <= out_sel_d;
            acc_clr_q  <= acc_clr_d;
            mac_oe_q   <= mac_oe_d;
            bias_oe_q  <= bias_oe_d;
`ifdef GOBOU_CTRL_RELU_EN
            relu_q     <= relu_d;
`endif
        end
    end

    assign ack          = ack_q;
    assign mem_img_addr = img_addr_q;
    assign img_we       = img_we_q;
    assign mem_net_addr = net_addr_q;
    assign out_sel      = out_sel_q;
    assign acc_clr      = acc_clr_q;
    assign mac_oe       = mac_oe_q;
    assign bias_oe      = bias_oe_q;
`ifdef GOBOU_CTRL_RELU_EN
    assign relu_oe      = relu_q;
`else
    assign relu_oe      = 1'b0;
`endif

endmodule

// File: tb/tb_gobou_ctrl.sv
// Scoreboard bench for gobou_ctrl: driver queues per-busy-cycle expectations, a negedge monitor checks them.
module tb_gobou_ctrl;

`ifdef GOBOU_CTRL_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        xrst;
    logic        req;
    logic [9:0]  total_out;
    logic [9:0]  total_in;
    logic [11:0] in_offset;
    logic [11:0] out_offset;
    logic [13:0] net_offset;
    logic        ack;
    logic [11:0] mem_img_addr;
    logic        img_we;
    logic [13:0] mem_net_addr;
    logic        acc_clr;
    logic        mac_oe;
    logic        bias_oe;
    logic [2:0]  out_sel;
    logic        relu_oe;

    gobou_ctrl #(.CORE(8), .LWIDTH(10), .IMGSIZE(12), .NETSIZE(14)) dut (
        .clk(clk), .xrst(xrst), .req(req),
        .total_out(total_out), .total_in(total_in),
        .in_offset(in_offset), .out_offset(out_offset), .net_offset(net_offset),
        .ack(ack), .mem_img_addr(mem_img_addr), .img_we(img_we),
        .mem_net_addr(mem_net_addr), .acc_clr(acc_clr), .mac_oe(mac_oe),
        .bias_oe(bias_oe), .out_sel(out_sel), .relu_oe(relu_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] img;
        logic [13:0] net;
        logic        chk_img;
        logic        chk_net;
        logic        we;
        logic [2:0]  sel;
        logic        relu;
        logic        mac;
        logic        acc;
        logic        bias;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_r;
    int   checks = 0;
    int   errors = 0;
    int   exp_busy;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one record per busy cycle, strobes reflect the previous cycle's phase.
    task automatic build_expect(input int tin, input int tout, input logic [11:0] ioff,
                                input logic [11:0] ooff, input logic [13:0] noff);
        logic        pw, pf, pb;
        int          oc, n;
        logic [13:0] p;
        rec_t        r;
        pw = 0; pf = 0; pb = 0; oc = 0; p = noff;
        exp_busy = 0;
        if (tin == 0 || tout == 0) return;
        while (oc < tout) begin
            for (int i = 0; i < tin; i++) begin
                r = '{img: ioff + 12'(i), net: p, chk_img: 1, chk_net: 1, we: 0, sel: 0,
                      relu: 0, mac: pw, acc: pf, bias: pb};
                exp_q.push_back(r);
                pw = 1; pf = (i == 0); pb = 0; p = p + 14'd1;
            end
            r = '{img: 0, net: p, chk_img: 0, chk_net: 1, we: 0, sel: 0,
                  relu: 0, mac: pw, acc: pf, bias: pb};
            exp_q.push_back(r);
            pw = 0; pf = 0; pb = 1; p = p + 14'd1;
            n = (tout - oc < 8) ? tout - oc : 8;
            for (int k = 0; k < n; k++) begin
                r = '{img: ooff + 12'(oc) + 12'(k), net: 0, chk_img: 1, chk_net: 0, we: 1,
                      sel: 3'(k), relu: RELU, mac: pw, acc: pf, bias: pb};
                exp_q.push_back(r);
                pw = 0; pf = 0; pb = 0;
            end
            oc += 8;
            exp_busy += tin + 1 + n;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ack === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_unexpected: got busy cycle expected idle at %0t", $time);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("strobes", {27'd0, img_we, mac_oe, acc_clr, bias_oe, relu_oe},
                        {27'd0, mon_r.we, mon_r.mac, mon_r.acc, mon_r.bias, mon_r.relu});
                    if (mon_r.chk_img) chk("img_addr", {20'd0, mem_img_addr}, {20'd0, mon_r.img});
                    if (mon_r.chk_net) chk("net_addr", {18'd0, mem_net_addr}, {18'd0, mon_r.net});
                    if (mon_r.we) chk("out_sel", {29'd0, out_sel}, {29'd0, mon_r.sel});
                end
            end else begin
                chk("idle_strobes", {27'd0, img_we, mac_oe, acc_clr, bias_oe, relu_oe}, 32'd0);
            end
        end
    end

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic run_op(input int tin, input int tout, input logic [11:0] ioff,
                          input logic [11:0] ooff, input logic [13:0] noff, input int glitch);
        int n;
        build_expect(tin, tout, ioff, ooff, noff);
        total_in = 10'(tin); total_out = 10'(tout);
        in_offset = ioff; out_offset = ooff; net_offset = noff;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        if (exp_busy == 0) begin
            repeat (20) @(negedge clk);
            chk("reject_ack", {31'd0, ack}, 32'd1);
            chk("reject_queue", exp_q.size(), 32'd0);
            return;
        end
        chk("accept_ack", {31'd0, ack}, 32'd0);
        n = 0;
        while (ack !== 1'b1 && n < 500) begin
            req = (glitch != 0 && n == glitch);
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        chk("busy_cycles", n, exp_busy);
        chk("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xrst = 1'b0; req = 1'b0;
        total_in = '0; total_out = '0; in_offset = '0; out_offset = '0; net_offset = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd1);
        chk("rst_strobes", {27'd0, img_we, mac_oe, acc_clr, bias_oe, relu_oe}, 32'd0);
        chk("rst_img_addr", {20'd0, mem_img_addr}, 32'd0);
        chk("rst_net_addr", {18'd0, mem_net_addr}, 32'd0);
        chk("rst_out_sel", {29'd0, out_sel}, 32'd0);

        // Release reset and request on the same edge.
        xrst = 1'b1;
        mon_en = 1'b1;
        run_op(4, 8, 12'h100, 12'h200, 14'h0000, 0);
        @(negedge clk);
        run_op(3, 10, 12'h010, 12'h300, 14'h1000, 0);
        @(negedge clk);
        run_op(0, 5, 12'h100, 12'h200, 14'h0000, 0);
        run_op(5, 0, 12'h100, 12'h200, 14'h0000, 0);
        run_op(4, 3, 12'hFFE, 12'hFFF, 14'h3FFE, 0);
        @(negedge clk);
        run_op(1, 1, 12'h040, 12'h050, 14'h0123, 0);
        run_op(4, 8, 12'h100, 12'h200, 14'h0000, 7);
        @(negedge clk);

        // Reset during the weight phase.
        build_expect(4, 8, 12'h100, 12'h200, 14'h0000);
        total_in = 10'd4; total_out = 10'd8;
        in_offset = 12'h100; out_offset = 12'h200; net_offset = 14'h0000;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        xrst = 1'b0;
        @(negedge clk);
        chk("midrst_ack", {31'd0, ack}, 32'd1);
        chk("midrst_strobes", {27'd0, img_we, mac_oe, acc_clr, bias_oe, relu_oe}, 32'd0);
        chk("midrst_img_addr", {20'd0, mem_img_addr}, 32'd0);
        xrst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        run_op(4, 8, 12'h100, 12'h200, 14'h0000, 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
